// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes one instruction per handshake and steers the ALU result mux through decode/execute/writeback
module alu_op_sequencer #(
  parameter int WIDTH       = 8,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [7:0]       instr,
  input  logic [WIDTH-1:0] alu_out,
  output logic [2:0]       select,
  output logic [1:0]       src_a,
  output logic [1:0]       src_b,
  output logic             wr_en,
  output logic [1:0]       wr_addr,
  output logic [WIDTH-1:0] wr_data,
  output logic             cmp_flag,
  output logic             done,
  output logic             illegal,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t state_q, state_d;
  logic [7:0] instr_q, instr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic cmp_flag_q, cmp_flag_d;
  logic illegal_q, illegal_d;
  logic [2:0] op;
  logic last;
  assign op   = instr_q[7:5];
  assign last = cnt_q == 4'(EXEC_CYCLES - 1);
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    wr_data_d  = wr_data_q;
    cmp_flag_d = cmp_flag_q;
    illegal_d  = 1'b0;
    case (state_q)
      IDLE: if (instr_valid) begin
        instr_d = instr;
        state_d = DECODE;
      end
      DECODE: begin
        illegal_d = op >= 3'd6;
        state_d   = op >= 3'd6 ? IDLE : EXEC;
      end
      EXEC: if (last) begin
        wr_data_d  = alu_out;
        cmp_flag_d = op == 3'd5 ? alu_out[0] : cmp_flag_q;
        cnt_d      = 4'd0;
        state_d    = WB;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      instr_q    <= 8'd0;
      cnt_q      <= 4'd0;
      wr_data_q  <= '0;
      cmp_flag_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      wr_data_q  <= wr_data_d;
      cmp_flag_q <= cmp_flag_d;
      illegal_q  <= illegal_d;
    end
  end
  // select is parked at 7 outside EXEC so the mux only re-evaluates for real ops
  assign select      = state_q == EXEC ? op : 3'b111;
  assign instr_ready = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign src_a       = instr_q[3:2];
  assign src_b       = instr_q[1:0];
  assign wr_addr     = instr_q[3:2];
  assign done        = state_q == WB;
  assign wr_en       = state_q == WB && op != 3'd5;
  assign wr_data     = wr_data_q;
  assign cmp_flag    = cmp_flag_q;
  assign illegal     = illegal_q;
endmodule
